// File: rtl/fir_audio_sched.sv
// rtl/fir_audio_sched.sv - round-robin scheduler sharing one audio FIR core between two channels
// Optional feature macro: FIR_SCHED_STATS_EN (per-channel 16-bit issue counters)
module fir_audio_sched #(
   parameter int IN_W       = 18,
   parameter int ACC_W      = 36,
   parameter int OUT_W      = 18,
   parameter int SHIFT      = 17,
   parameter int TAG_DEPTH  = 8,
   parameter int CLR_CYCLES = 2
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             flush,
   input  logic [IN_W-1:0]  ch0_din,
   input  logic             ch0_valid,
   output logic             ch0_ready,
   input  logic [IN_W-1:0]  ch1_din,
   input  logic             ch1_valid,
   output logic             ch1_ready,
   output logic             fir_nd,
   output logic [IN_W-1:0]  fir_din,
   input  logic             fir_rfd,
   input  logic             fir_rdy,
   input  logic [ACC_W-1:0] fir_dout,
   output logic             fir_sclr,
   output logic [OUT_W-1:0] ch0_dout,
   output logic             ch0_dvalid,
   output logic [OUT_W-1:0] ch1_dout,
   output logic             ch1_dvalid,
   output logic             tag_err,
   output logic [15:0]      ch0_cnt,
   output logic [15:0]      ch1_cnt
);

   localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;

   localparam logic signed [ACC_W:0] RND_ADD = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t              state;
   logic                h0_full, h1_full;
   logic [IN_W-1:0]     h0_data, h1_data;
   logic                last_ch, grant_ch;
   logic [1:0]          wait_cnt;
   logic                seen_low;

   logic                tag_mem [TAG_DEPTH];
   logic [TAG_AW-1:0]   wr_ptr, rd_ptr;
   logic [TAG_AW:0]     tag_cnt;
   logic [CLR_W-1:0]    clr_cnt;
   logic [TAG_AW:0]     disc_cnt;

   logic                tag_full, tag_empty, discard, push, pop, issue_ok, next_grant;
   logic signed [ACC_W:0] rnd_sum, rnd_shift;
   logic [OUT_W-1:0]    sat_val;

   assign ch0_ready  = ~h0_full;
   assign ch1_ready  = ~h1_full;
   assign tag_full   = (tag_cnt == (TAG_AW + 1)'(TAG_DEPTH));
   assign tag_empty  = (tag_cnt == '0);
   assign discard    = (disc_cnt != '0);
   assign push       = (state == S_ISSUE);
   assign pop        = fir_rdy && !tag_empty && !discard;
   // a pop in the same cycle frees the slot this issue will occupy
   assign issue_ok   = fir_rfd && (h0_full || h1_full) && (!tag_full || pop);
   assign next_grant = (h0_full && h1_full) ? ~last_ch : h1_full;

   // round and saturate the core result into the channel output width
   always_comb begin
      rnd_sum   = $signed({fir_dout[ACC_W-1], fir_dout}) + RND_ADD;
      rnd_shift = rnd_sum >>> SHIFT;
      sat_val   = rnd_shift[OUT_W-1:0];
      if (rnd_shift > SAT_MAX)
         sat_val = SAT_MAX[OUT_W-1:0];
      else if (rnd_shift < SAT_MIN)
         sat_val = SAT_MIN[OUT_W-1:0];
   end

   // one-entry holding registers; a slot empties in the cycle its sample is issued
   always_ff @(posedge clk) begin
      if (sclr || flush) begin
         h0_full <= 1'b0;
         h1_full <= 1'b0;
         h0_data <= '0;
         h1_data <= '0;
      end else begin
         if (push && !grant_ch)
            h0_full <= 1'b0;
         else if (ch0_valid && !h0_full) begin
            h0_full <= 1'b1;
            h0_data <= ch0_din;
         end
         if (push && grant_ch)
            h1_full <= 1'b0;
         else if (ch1_valid && !h1_full) begin
            h1_full <= 1'b1;
            h1_data <= ch1_din;
         end
      end
   end

   // issue FSM: grant round-robin, strobe nd once, then wait for the core to take it
   always_ff @(posedge clk) begin
      if (sclr || flush) begin
         state    <= S_IDLE;
         fir_nd   <= 1'b0;
         fir_din  <= '0;
         grant_ch <= 1'b0;
         last_ch  <= 1'b1;
         wait_cnt <= '0;
         seen_low <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue_ok) begin
                  grant_ch <= next_grant;
                  fir_din  <= next_grant ? h1_data : h0_data;
                  fir_nd   <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               fir_nd   <= 1'b0;
               last_ch  <= grant_ch;
               wait_cnt <= '0;
               seen_low <= 1'b0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt != 2'd3)
                  wait_cnt <= wait_cnt + 2'd1;
               if (!fir_rfd)
                  seen_low <= 1'b1;
               else if (seen_low || wait_cnt == 2'd3)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // tag storage holds the channel id of each in-flight sample
   always_ff @(posedge clk) begin
      if (push)
         tag_mem[wr_ptr] <= grant_ch;
   end

   // tag FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (sclr || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + TAG_AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + TAG_AW'(1);
         if (push && !pop)
            tag_cnt <= tag_cnt + (TAG_AW + 1)'(1);
         else if (!push && pop)
            tag_cnt <= tag_cnt - (TAG_AW + 1)'(1);
      end
   end

   // route results to the tagged channel; orphan results flag tag_err
   always_ff @(posedge clk) begin
      if (sclr) begin
         ch0_dout   <= '0;
         ch1_dout   <= '0;
         ch0_dvalid <= 1'b0;
         ch1_dvalid <= 1'b0;
         tag_err    <= 1'b0;
      end else if (flush) begin
         ch0_dvalid <= 1'b0;
         ch1_dvalid <= 1'b0;
         tag_err    <= 1'b0;
      end else begin
         ch0_dvalid <= 1'b0;
         ch1_dvalid <= 1'b0;
         if (pop) begin
            if (tag_mem[rd_ptr]) begin
               ch1_dout   <= sat_val;
               ch1_dvalid <= 1'b1;
            end else begin
               ch0_dout   <= sat_val;
               ch0_dvalid <= 1'b1;
            end
         end else if (fir_rdy && tag_empty && !discard) begin
            tag_err <= 1'b1;
         end
      end
   end

   // core clear pulse and post-flush window in which stale results are dropped
   always_ff @(posedge clk) begin
      if (sclr) begin
         fir_sclr <= 1'b1;
         clr_cnt  <= '0;
         disc_cnt <= '0;
      end else if (flush) begin
         fir_sclr <= 1'b1;
         clr_cnt  <= CLR_W'(CLR_CYCLES - 1);
         disc_cnt <= (TAG_AW + 1)'(TAG_DEPTH);
      end else begin
         fir_sclr <= (clr_cnt != '0);
         if (clr_cnt != '0)
            clr_cnt <= clr_cnt - CLR_W'(1);
         if (disc_cnt != '0)
            disc_cnt <= disc_cnt - (TAG_AW + 1)'(1);
      end
   end

`ifdef FIR_SCHED_STATS_EN
   // per-channel issue counters, wrapping at 16 bits
   always_ff @(posedge clk) begin
      if (sclr || flush) begin
         ch0_cnt <= '0;
         ch1_cnt <= '0;
      end else if (push) begin
         if (grant_ch)
            ch1_cnt <= ch1_cnt + 16'd1;
         else
            ch0_cnt <= ch0_cnt + 16'd1;
      end
   end
`else
   assign ch0_cnt = '0;
   assign ch1_cnt = '0;
`endif

endmodule
